// File: rtl/led_scan_pkg.sv
// Shared constants and types for the LED row scanner.
//   NUM_ROWS / ROW_W : display geometry (8 rows, 3-bit decoder code)
//   PWM_W            : width of the brightness PWM counter (dimming build)
//   scan_state_e     : scanner phase, BLANK between rows, SHOW while lit
//   timer_width()    : phase timer width for the given dwell/blank lengths
package led_scan_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned PWM_W    = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Enough bits to hold max(a, b) - 1, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the BLANK and SHOW phases.
//   clk, reset : clock, synchronous active-high reset (count <= RST_VAL)
//   load       : load load_val this cycle (wins over counting)
//   load_val   : phase length minus one
//   tc_c       : terminal count, high in the last cycle of the phase
module scan_timer #(
    parameter int unsigned   W       = 2,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc_c
);

    logic [W-1:0] count;

    // Count remaining cycles of the current phase down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc_c = (count == '0);

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row scanner for the 8-row LED note display with a double-buffered frame
// store. Game logic writes the back buffer; buffers swap only at the frame
// boundary (end of row 7's lit phase), so a frame is never shown torn.
// Build option: define LED_SCAN_DIM_EN to add PWM dimming via 'bright'.
//   clk, reset  : clock, synchronous active-high reset
//   wr_en       : write wr_data into back-buffer row wr_row
//   swap_req    : level request, held until swap_ack
//   bright      : (LED_SCAN_DIM_EN only) 4-bit brightness, 15 = full
//   swap_ack    : one-cycle pulse when the buffers swap
//   row_sel     : row code to the 3-to-8 decoder
//   row_valid   : high while the row is lit
//   col_out     : column data, zero whenever row_valid is low
//   frame_done  : one-cycle pulse after row 7's lit phase
module led_row_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int unsigned COLS      = 16,
    parameter int unsigned DWELL_CYC = 2000,
    parameter int unsigned BLANK_CYC = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic             swap_req,
`ifdef LED_SCAN_DIM_EN
    input  logic [PWM_W-1:0] bright,
`endif
    output logic             swap_ack,
    output logic [ROW_W-1:0] row_sel,
    output logic             row_valid,
    output logic [COLS-1:0]  col_out,
    output logic             frame_done
);

    localparam int unsigned TIMER_W = timer_width(DWELL_CYC, BLANK_CYC);
    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYC - 1);
    localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_CYC - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);

    scan_state_e      state;
    logic [ROW_W-1:0] cur_row;
    logic             bank;
    logic             swap_pend;
    logic [COLS-1:0]  buf0 [NUM_ROWS];
    logic [COLS-1:0]  buf1 [NUM_ROWS];

    logic               tc_c;
    logic [TIMER_W-1:0] load_val_c;
    logic [COLS-1:0]    front_c;
    logic               lit_c;

    // Reload at the end of each phase with the length of the phase that follows.
    assign load_val_c = (state == BLANK) ? DWELL_LOAD : BLANK_LOAD;

    // Timer resets to a full blank phase: zero cycles of blanking elapsed.
    scan_timer #(
        .W       (TIMER_W),
        .RST_VAL (BLANK_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tc_c),
        .load_val (load_val_c),
        .tc_c     (tc_c)
    );

    // Front buffer row, read live every lit cycle.
    assign front_c = bank ? buf1[cur_row] : buf0[cur_row];

`ifdef LED_SCAN_DIM_EN
    logic [PWM_W-1:0] pwm;
    logic [PWM_W-1:0] bright_q;
    logic [PWM_W-1:0] bright_eff_c;

    // Free-running PWM phase; brightness latched once per row on entry to SHOW.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm      <= '0;
            bright_q <= '0;
        end else begin
            pwm <= pwm + PWM_W'(1);
            if (state == BLANK && tc_c) begin
                bright_q <= bright;
            end
        end
    end

    // On the BLANK->SHOW edge the fresh bright value applies immediately.
    assign bright_eff_c = (state == BLANK) ? bright : bright_q;
    assign lit_c        = (pwm < bright_eff_c) || (bright_eff_c == '1);
`else
    assign lit_c = 1'b1;
`endif

    // Scan FSM, frame store, swap handshake and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            cur_row    <= '0;
            bank       <= 1'b0;
            swap_pend  <= 1'b0;
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= '0;
            row_valid  <= 1'b0;
            col_out    <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                buf0[r] <= '0;
                buf1[r] <= '0;
            end
        end else begin
            swap_ack   <= 1'b0;
            frame_done <= 1'b0;

            if (swap_req) begin
                swap_pend <= 1'b1;
            end

            // Back buffer is selected by the pre-swap bank, even on the swap edge.
            if (wr_en) begin
                if (bank) begin
                    buf0[wr_row] <= wr_data;
                end else begin
                    buf1[wr_row] <= wr_data;
                end
            end

            unique case (state)
                BLANK: begin
                    row_sel <= cur_row;
                    if (tc_c) begin
                        state     <= SHOW;
                        row_valid <= lit_c;
                        col_out   <= lit_c ? front_c : '0;
                    end else begin
                        row_valid <= 1'b0;
                        col_out   <= '0;
                    end
                end
                SHOW: begin
                    if (tc_c) begin
                        state     <= BLANK;
                        cur_row   <= cur_row + ROW_W'(1);
                        row_sel   <= cur_row + ROW_W'(1);
                        row_valid <= 1'b0;
                        col_out   <= '0;
                        if (cur_row == LAST_ROW) begin
                            frame_done <= 1'b1;
                            if (swap_pend || swap_req) begin
                                bank      <= ~bank;
                                swap_ack  <= 1'b1;
                                swap_pend <= 1'b0;
                            end
                        end
                    end else begin
                        row_sel   <= cur_row;
                        row_valid <= lit_c;
                        col_out   <= lit_c ? front_c : '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Directed bench for led_row_scan_ctrl (COLS=16, DWELL_CYC=4, BLANK_CYC=2).
// Each step drives inputs, pushes the expected next-cycle outputs derived
// from the scan timing (row period 6, frame period 48) and a frame-store
// model, then pops and compares one cycle later.
module tb_led_row_scan_ctrl;

    localparam int COLS  = 16;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int ROWP  = DWELL + BLANK;
    localparam int FRAME = 8 * ROWP;

    typedef struct packed {
        logic [2:0]  row_sel;
        logic        row_valid;
        logic        frame_done;
        logic        swap_ack;
        logic [15:0] col_out;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_row = '0;
    logic [15:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic [2:0]  row_sel;
    logic        row_valid;
    logic [15:0] col_out;
    logic        frame_done;
`ifdef LED_SCAN_DIM_EN
    logic [3:0]  bright = 4'd15;
`endif

    led_row_scan_ctrl #(
        .COLS      (COLS),
        .DWELL_CYC (DWELL),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
`ifdef LED_SCAN_DIM_EN
        .bright     (bright),
`endif
        .swap_ack   (swap_ack),
        .row_sel    (row_sel),
        .row_valid  (row_valid),
        .col_out    (col_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: period index since reset (1 = period after the reset edge).
    int          mk = 1;
    int          mbank = 0;
    bit          mpend = 1'b0;
    logic [15:0] mb [2][8];
    obs_t        sb_q [$];
    bit          req_hold = 1'b0;
    bit          saw_ack = 1'b0;
    int          acks = 0;

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got sel=%0d v=%b fd=%b ack=%b col=%h exp sel=%0d v=%b fd=%b ack=%b col=%h",
                   tag, mk, got.row_sel, got.row_valid, got.frame_done, got.swap_ack, got.col_out,
                   exp.row_sel, exp.row_valid, exp.frame_done, exp.swap_ack, exp.col_out);
        end
    endtask

    // One clock: drive at negedge, model the edge, compare just after it.
    task automatic step(input logic rst, input logic we, input logic [2:0] wr,
                        input logic [15:0] wd, input string tag);
        obs_t exp;
        obs_t got;
        logic sreq;
        bit   swapped;
        int   p;
        int   row;
        sreq     = req_hold;
        reset    = rst;
        wr_en    = we;
        wr_row   = wr;
        wr_data  = wd;
        swap_req = sreq;
        swapped  = 1'b0;
        if (rst) begin
            mk    = 1;
            mbank = 0;
            mpend = 1'b0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    mb[b][r] = '0;
        end else begin
            mk = mk + 1;
            if (we) mb[mbank ^ 1][wr] = wd;
            if (((mk - 1) % FRAME) == 0) begin
                if (mpend || sreq) begin
                    mbank   = mbank ^ 1;
                    mpend   = 1'b0;
                    swapped = 1'b1;
                end
            end else if (sreq) begin
                mpend = 1'b1;
            end
        end
        p   = (mk - 1) % ROWP;
        row = ((mk - 1) / ROWP) % 8;
        exp.row_sel    = 3'(row);
        exp.row_valid  = (p >= BLANK);
        exp.frame_done = (mk > 1) && (((mk - 1) % FRAME) == 0);
        exp.swap_ack   = swapped;
        exp.col_out    = (p >= BLANK) ? mb[mbank][row] : 16'h0000;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        got = '{row_sel: row_sel, row_valid: row_valid, frame_done: frame_done,
                swap_ack: swap_ack, col_out: col_out};
        check(tag, got, sb_q.pop_front());
        if (swap_ack) begin
            req_hold = 1'b0;
            saw_ack  = 1'b1;
            acks++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 16'h0, tag);
    endtask

    // Step until the current period index satisfies (mk - 1) % FRAME == target.
    task automatic idle_until(input int target, input string tag);
        int n;
        n = 0;
        while ((((mk - 1) % FRAME) != target) && (n < 2 * FRAME)) begin
            step(1'b0, 1'b0, 3'd0, 16'h0, tag);
            n++;
        end
        total++;
        assert (n < 2 * FRAME) else begin
            bad++;
            $error("FAIL %s_timeout got steps=%0d exp <%0d", tag, n, 2 * FRAME);
        end
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        saw_ack = 1'b0;
        while (!saw_ack && n < 3 * FRAME) begin
            step(1'b0, 1'b0, 3'd0, 16'h0, tag);
            n++;
        end
        total++;
        assert (saw_ack) else begin
            bad++;
            $error("FAIL %s_noack got ack=%b exp ack=1", tag, saw_ack);
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++)
                mb[b][r] = '0;
        @(negedge clk);

        // Reset state, then one frame plus a bit with nothing written.
        step(1'b1, 1'b0, 3'd0, 16'h0, "reset");
        step(1'b1, 1'b0, 3'd0, 16'h0, "reset");
        idle(FRAME + 12, "blank_frame");

        // Row 3 = A5A5 with a held swap request; show the following frame.
        step(1'b0, 1'b1, 3'd3, 16'hA5A5, "wr_row3");
        req_hold = 1'b1;
        wait_ack("swap1");
        idle(FRAME, "show_a5a5");

        // Row 5 written without a swap: displayed frame stays unchanged.
        step(1'b0, 1'b1, 3'd5, 16'hFFFF, "wr_row5");
        idle(3 * FRAME, "no_swap");

        // Write on the swap edge lands in the new front buffer.
        idle_until(FRAME - 1, "align");
        req_hold = 1'b1;
        step(1'b0, 1'b1, 3'd0, 16'h1234, "wr_on_swap");
        idle(FRAME, "show_1234");

        // Reset during row 4's lit phase, then scan restarts from row 0.
        idle_until(4 * ROWP + BLANK + 1, "align_r4");
        step(1'b1, 1'b0, 3'd0, 16'h0, "reset_mid");
        idle(FRAME + 4, "after_reset");

        // Swap again with no writes: both buffers must have been cleared.
        req_hold = 1'b1;
        wait_ack("swap_clr");
        idle(FRAME, "cleared");

        total++;
        assert (acks == 3) else begin
            bad++;
            $error("FAIL ack_count got=%0d exp=3", acks);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
